// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: default sizing constants and width helpers for stream_fifo.
package stream_fifo_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 16;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/stream_fifo_ram.sv
// stream_fifo_ram: one-write/one-read storage array, asynchronous read, no reset.
module stream_fifo_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with registered-read or FWFT output and occupancy flags.
// Optional sticky overflow/underflow outputs when STREAM_FIFO_ERR_EN is defined.
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       din,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count
`ifdef STREAM_FIFO_ERR_EN
   ,
   output logic                   overflow,
   output logic                   underflow
`endif
);
   localparam int AW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] C_AF   = CW'(AFULL_TH);
   localparam logic [CW-1:0] C_AE   = CW'(AEMPTY_TH);

   logic [AW-1:0]    wptr, rptr;
   logic [WIDTH-1:0] head;
   logic             wr_ok, rd_ok;

   assign full         = count == C_FULL;
   assign empty        = count == '0;
   assign almost_full  = count >= C_AF;
   assign almost_empty = count <= C_AE;
   // A pop in the same cycle frees the slot the write needs, even when full.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wr_ok ? wptr + AW'(1) : wptr;
         rptr  <= rd_ok ? rptr + AW'(1) : rptr;
         count <= (wr_ok && !rd_ok) ? count + CW'(1) : (rd_ok && !wr_ok) ? count - CW'(1) : count;
      end

   stream_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk  (clk),
      .we   (wr_ok),
      .waddr(wptr),
      .wdata(din),
      .raddr(rptr),
      .rdata(head)
   );

   if (FWFT != 0) begin : g_fwft
      assign dout = empty ? '0 : head;
   end else begin : g_reg
      logic [WIDTH-1:0] dq;
      always_ff @(posedge clk or posedge rst)
         if (rst) dq <= '0;
         else if (rd_ok) dq <= head;
      assign dout = dq;
   end

`ifdef STREAM_FIFO_ERR_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow | (wr_en & ~wr_ok);
         underflow <= underflow | (rd_en & ~rd_ok);
      end
`endif
endmodule
